mips_trace_unit: RTL and testbench

- Execution trace capture stage downstream of the single-cycle MIPS core.
- Samples the core's per-instruction observables each clock while enabled: current PC, ALU result, data-memory read data.
- Buffers samples in a FIFO and streams them to a debug host as 12-byte records over an 8-bit valid/ready byte interface.
- Lets the bench or board observe program execution without stalling the core.

---
 rtl/mips_trace_unit.sv | 205 ++++++++++++++++++++
 tb/tb_mips_trace_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_trace_unit.sv
// -----------------------------------------------------------------------------
// mips_trace_unit
//
// Execution trace capture stage that sits downstream of the single-cycle MIPS
// core. While trace_en is high, the unit captures one sample per clock. Each
// sample holds the current PC, the ALU result and the data-memory read data.
// Samples are buffered in a FIFO so the core never stalls. They are streamed
// to a debug host as 12-byte big-endian records over a valid/ready byte
// interface.
//
// Record layout (96 bits, byte 0 first on the wire):
//   bytes 0..3  = pc_in   (MSB first)
//   bytes 4..7  = alu_in  (MSB first)
//   bytes 8..11 = mem_in  (MSB first)
//
// Ports:
//   clock      in   1         system clock, rising-edge active
//   reset      in   1         synchronous, active-low reset
//   trace_en   in   1         capture enable, one sample per clock while high
//   clear      in   1         synchronous flush of FIFO, serializer, overflow
//   pc_in      in   32        core current PC
//   alu_in     in   32        core ALU result
//   mem_in     in   32        core data-memory read data
//   out_valid  out  1         out_byte holds a valid record byte
//   out_ready  in   1         host accepts out_byte on this edge
//   out_byte   out  8         serialized record byte
//   out_last   out  1         high with byte 11 of a record
//   count      out  ADDR_W+1  FIFO occupancy (record in serializer excluded)
//   overflow   out  1         sticky, a sample was dropped
// -----------------------------------------------------------------------------
module mips_trace_unit #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              trace_en,
  input  logic              clear,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       mem_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] L_DEPTH    = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      L_LAST_IDX = 4'd11;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;

  logic [95:0]         r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wrPtr;
  logic [ADDR_W-1:0]   r_rdPtr;
  logic [ADDR_W:0]     r_count;
  logic                r_overflow;

  // The current record is shifted left one byte per accepted byte. The byte
  // on the wire is therefore always the top byte of r_shift.
  logic [95:0]         r_shift;
  logic [3:0]          r_index;
  logic [3:0]          w_indexNext;

  logic                w_run;
  logic                w_fifoEmpty;
  logic                w_fifoFull;
  logic                w_pop;
  logic                w_push;
  logic                w_pushEn;
  logic                w_popEn;
  logic                w_shiftOut;

  // Reset and clear both block normal operation on this edge. trace_en is
  // ignored whenever either one is active.
  assign w_run       = reset && !clear;
  assign w_fifoEmpty = (r_count == '0);
  assign w_fifoFull  = (r_count == L_DEPTH);

  // A full FIFO still accepts a sample when a pop frees a slot on the same
  // edge. The pop reads the old head before the write lands, so a new sample
  // can never pass straight through to the serializer.
  assign w_push   = trace_en && (!w_fifoFull || w_pop);
  assign w_pushEn = w_run && w_push;
  assign w_popEn  = w_run && w_pop;

  // State register for the serializer FSM.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state, pop request and output decode for the serializer FSM.
  always_comb begin
    w_stateNext = r_state;
    w_indexNext = r_index;
    w_pop       = 1'b0;
    w_shiftOut  = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_byte    = 8'h00;

    case (r_state)
      ST_IDLE: begin
        if (!w_fifoEmpty) begin
          w_pop       = 1'b1;
          w_indexNext = 4'd0;
          w_stateNext = ST_SEND;
        end
      end

      ST_SEND: begin
        out_valid = 1'b1;
        out_byte  = r_shift[95:88];
        out_last  = (r_index == L_LAST_IDX);
        if (out_ready) begin
          if (r_index != L_LAST_IDX) begin
            w_indexNext = r_index + 4'd1;
            w_shiftOut  = 1'b1;
          end else if (!w_fifoEmpty) begin
            // Back-to-back records: reload without a bubble cycle.
            w_pop       = 1'b1;
            w_indexNext = 4'd0;
          end else begin
            w_indexNext = 4'd0;
            w_stateNext = ST_IDLE;
          end
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
        w_indexNext = 4'd0;
      end
    endcase
  end

  // FIFO storage. The memory holds no reset state because occupancy is
  // tracked entirely by r_count and the pointers.
  always_ff @(posedge clock) begin
    if (w_pushEn) begin
      r_mem[r_wrPtr] <= {pc_in, alu_in, mem_in};
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag. The pointers wrap
  // naturally at DEPTH because DEPTH is a power of two. Full and empty come
  // from r_count, so equal pointers are never ambiguous.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (trace_en && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Serializer shift register and byte index. When out_ready is low, nothing
  // changes, so the byte on the wire holds steady.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      r_shift <= '0;
      r_index <= 4'd0;
    end else begin
      r_index <= w_indexNext;
      if (w_popEn) begin
        r_shift <= r_mem[r_rdPtr];
      end else if (w_shiftOut) begin
        r_shift <= {r_shift[87:0], 8'h00};
      end
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_mips_trace_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_trace_unit
//
// Directed bench for mips_trace_unit. A queue-based reference model tracks
// what the unit must hold after every edge: the FIFO contents, the record
// being sent and its byte position, and the overflow flag. A compare process
// checks every DUT output against that model on each falling edge. Each byte
// the host accepts is also logged. The scenarios check this log against
// hand-written byte sequences.
// -----------------------------------------------------------------------------
module tb_mips_trace_unit;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              trace_en;
  logic              clear;
  logic [31:0]       pc_in;
  logic [31:0]       alu_in;
  logic [31:0]       mem_in;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic              out_last;
  logic [ADDR_W:0]   count;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  mips_trace_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .trace_en  (trace_en),
    .clear     (clear),
    .pc_in     (pc_in),
    .alu_in    (alu_in),
    .mem_in    (mem_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  // Reference model state
  bit [95:0] mq [$];
  bit        mBusy   = 1'b0;
  bit [95:0] mCur    = '0;
  int        mIdx    = 0;
  bit        mOvf    = 1'b0;
  bit        started = 1'b0;

  // Bytes accepted by the host, stored as {last, byte}
  logic [8:0] cap [$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] modelByte();
    if (!mBusy) return 8'h00;
    return mCur[95 - 8*mIdx -: 8];
  endfunction

  // Model update, applied at the same edge as the DUT using the inputs that
  // are stable across that edge. The pop decision uses the pre-edge
  // occupancy, which prevents a sample from passing straight through.
  always @(posedge clock) begin
    bit pop;
    int sz;
    if (!reset || clear) begin
      mq.delete();
      mBusy = 1'b0;
      mCur  = '0;
      mIdx  = 0;
      mOvf  = 1'b0;
    end else begin
      sz  = mq.size();
      pop = 1'b0;
      if (!mBusy) begin
        if (sz > 0) pop = 1'b1;
      end else if (out_ready) begin
        if (mIdx < 11)   mIdx++;
        else if (sz > 0) pop = 1'b1;
        else             mBusy = 1'b0;
      end
      if (pop) begin
        mCur  = mq.pop_front();
        mIdx  = 0;
        mBusy = 1'b1;
      end
      if (trace_en) begin
        if (sz < DEPTH || pop) mq.push_back({pc_in, alu_in, mem_in});
        else                   mOvf = 1'b1;
      end
    end
    started = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (started) begin
      checkOutput("out_valid", 32'(out_valid), 32'(mBusy));
      checkOutput("out_byte",  32'(out_byte),  32'(modelByte()));
      checkOutput("out_last",  32'(out_last),  32'(mBusy && (mIdx == 11)));
      checkOutput("count",     32'(count),     32'(mq.size()));
      checkOutput("overflow",  32'(overflow),  32'(mOvf));
    end
  end

  // Log every byte that the next rising edge will hand to the host
  always @(negedge clock) begin
    if (started && out_valid && out_ready) cap.push_back({out_last, out_byte});
  end

  // Drive one cycle of inputs and advance past the next rising edge
  task automatic applyStimulus(input logic en, input logic clr, input logic rdy,
                               input logic [31:0] pc, input logic [31:0] alu,
                               input logic [31:0] mem);
    trace_en  = en;
    clear     = clr;
    out_ready = rdy;
    pc_in     = pc;
    alu_in    = alu;
    mem_in    = mem;
    @(posedge clock);
    #2;
  endtask

  task automatic checkBytes(input string name, input logic [7:0] exp [12]);
    checkOutput({name, " byte count"}, 32'(cap.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < cap.size()) begin
        checkOutput({name, " byte"}, 32'(cap[i][7:0]), 32'(exp[i]));
        checkOutput({name, " last"}, 32'(cap[i][8]), 32'(i == 11));
      end
    end
  endtask

  logic [7:0] rec2 [12] = '{8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h2A, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [7:0] rec6 [12] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                            8'hDE, 8'hF0, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
  logic       rdyPat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] pcGot;

    // Reset: two edges with trace_en high; nothing may be captured
    reset     = 1'b0;
    trace_en  = 1'b1;
    clear     = 1'b0;
    out_ready = 1'b0;
    pc_in     = 32'h00400000;
    alu_in    = 32'h11111111;
    mem_in    = 32'h22222222;
    @(posedge clock);
    #2;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h00400000, 32'h11111111, 32'h22222222);
    checkOutput("reset valid",    32'(out_valid), 32'd0);
    checkOutput("reset byte",     32'(out_byte),  32'h00);
    checkOutput("reset count",    32'(count),     32'd0);
    checkOutput("reset overflow", 32'(overflow),  32'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    checkOutput("post-reset count", 32'(count), 32'd0);

    // Single record: first out_valid one cycle after the capture edge
    cap.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h00400000, 32'h0000002A, 32'hDEADBEEF);
    checkOutput("s2 valid at capture+0", 32'(out_valid), 32'd0);
    checkOutput("s2 count at capture+0", 32'(count),     32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    checkOutput("s2 valid at capture+1", 32'(out_valid), 32'd1);
    checkOutput("s2 first byte",         32'(out_byte),  32'h00);
    repeat (14) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    checkBytes("s2", rec2);
    checkOutput("s2 idle after record", 32'(out_valid), 32'd0);

    // Backpressure with out_ready pattern 1,0,0,1
    cap.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h00400000, 32'h0000002A, 32'hDEADBEEF);
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b0, 1'b0, rdyPat[i % 4], 32'h0, 32'h0, 32'h0);
    end
    checkBytes("s3", rec2);

    // Overflow: 20 samples while the host stalls
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h00400000 + 32'(4*k), 32'(k), ~32'(k));
    end
    checkOutput("s4 count full",    32'(count),     32'd16);
    checkOutput("s4 overflow",      32'(overflow),  32'd1);
    checkOutput("s4 serializer",    32'(out_valid), 32'd1);
    cap.delete();
    repeat (17*12 + 4) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    checkOutput("s4 drained bytes", 32'(cap.size()), 32'd204);
    for (int r = 0; r < 17; r++) begin
      if (12*r + 11 < cap.size()) begin
        pcGot = {cap[12*r][7:0], cap[12*r+1][7:0], cap[12*r+2][7:0], cap[12*r+3][7:0]};
        checkOutput("s4 record pc",   pcGot, 32'h00400000 + 32'(4*r));
        checkOutput("s4 record last", 32'(cap[12*r+11][8]), 32'd1);
      end
    end
    checkOutput("s4 count empty",     32'(count),    32'd0);
    checkOutput("s4 overflow sticky", 32'(overflow), 32'd1);

    // Full with simultaneous pop on the final-byte edge
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("s5 clear overflow", 32'(overflow), 32'd0);
    checkOutput("s5 clear count",    32'(count),    32'd0);
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h00500000 + 32'(4*k), 32'(k), 32'(k));
    end
    checkOutput("s5 count full", 32'(count),    32'd16);
    checkOutput("s5 no overflow", 32'(overflow), 32'd0);
    repeat (11) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    checkOutput("s5 on last byte", 32'(out_last), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h00600000, 32'h0, 32'h0);
    checkOutput("s5 count held",     32'(count),    32'd16);
    checkOutput("s5 overflow held",  32'(overflow), 32'd0);
    checkOutput("s5 next record",    32'(out_byte), 32'h00);
    checkOutput("s5 next not last",  32'(out_last), 32'd0);
    repeat (17*12 + 4) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    checkOutput("s5 drained", 32'(count), 32'd0);

    // Clear mid-record with count=3
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h00700000 + 32'(4*k), 32'h0, 32'h0);
    end
    checkOutput("s6 count before", 32'(count), 32'd3);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    checkOutput("s6 at byte 6", 32'(out_byte), 32'h00);
    cap.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0);
    checkOutput("s6 valid cleared",    32'(out_valid), 32'd0);
    checkOutput("s6 count cleared",    32'(count),     32'd0);
    checkOutput("s6 overflow cleared", 32'(overflow),  32'd0);
    checkOutput("s6 byte cleared",     32'(out_byte),  32'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C);
    repeat (14) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    checkBytes("s6", rec6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
